param_serializer: RTL

PARAM_SERIALIZER -- requirements
Module: param_serializer

---
 rtl/ser_pkg.sv | 14 +
 rtl/ser_parity_gen.sv | 23 ++
 rtl/param_serializer.sv | 112 +++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared FSM state type and count-width helper for param_serializer
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Width of the bit counter; never below one bit so the counter stays a real register
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/ser_parity_gen.sv
// rtl/ser_parity_gen.sv - parity bit captured when a word is loaded into the serializer
module ser_parity_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  par_bit
);

    localparam logic ODD_SEL = (PARITY_ODD != 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (load) begin
            par_bit <= (^data) ^ ODD_SEL;
        end
    end

endmodule

// File: rtl/param_serializer.sv
// rtl/param_serializer.sv - parallel-to-serial shifter with back-to-back loads; SER_PARITY_EN adds Par_bit
module param_serializer
    import ser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  Msb_first,
    input  logic                  Ser_en,
    output logic                  Ready,
    output logic                  Busy,
    output logic                  Ser_data,
    output logic                  Ser_done
`ifdef SER_PARITY_EN
    ,
    output logic                  Par_bit
`endif
);

    localparam int CW = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    ser_state_e            state_q;
    ser_state_e            state_d;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [CW-1:0]         cnt_q;
    logic                  msb_q;
    logic                  load;
    logic                  shift;
    logic                  last_shift;

    always_comb begin
        state_d    = state_q;
        Ready      = 1'b0;
        shift      = 1'b0;
        last_shift = 1'b0;
        case (state_q)
            IDLE: begin
                Ready = 1'b1;
            end
            SHIFT: begin
                shift      = Ser_en;
                last_shift = Ser_en && (cnt_q == LAST_CNT);
                Ready      = last_shift;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        load = Data_Valid && Ready;
        // A load on the final shift keeps us in SHIFT so the next word follows with no gap
        if (load) begin
            state_d = SHIFT;
        end else if (last_shift) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            msb_q    <= 1'b0;
            Ser_data <= 1'b0;
            Ser_done <= 1'b0;
        end else begin
            Ser_done <= last_shift;
            if (shift) begin
                Ser_data <= msb_q ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
            end
            if (load) begin
                shreg_q <= P_DATA;
                msb_q   <= Msb_first;
                cnt_q   <= '0;
            end else if (shift) begin
                shreg_q <= msb_q ? (shreg_q << 1) : (shreg_q >> 1);
                cnt_q   <= last_shift ? '0 : cnt_q + CW'(1);
            end
        end
    end

    assign Busy = (state_q == SHIFT);

`ifdef SER_PARITY_EN
    ser_parity_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .PARITY_ODD (PARITY_ODD)
    ) u_parity (
        .clk     (CLK),
        .rst     (RST),
        .load    (load),
        .data    (P_DATA),
        .par_bit (Par_bit)
    );
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

endmodule
